// File: rtl/wave_sched_pkg.sv
// rtl/wave_sched_pkg.sv - shared types and widths for the Wave MAC bit scheduler
// Contents: scheduler state enum, magnitude width, column index width.
package wave_sched_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int MAG_WIDTH      = DEF_DATA_WIDTH - 1;
  localparam int COL_IDX_WIDTH  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/wave_bit_scheduler_if.sv
// rtl/wave_bit_scheduler_if.sv - group input handshake bundle for the bit scheduler
// Signals: in_valid (group offered), in_ready (scheduler accepts),
//          weight_in (sign-magnitude weights per lane), act_in (activations per lane).
// Modports: master drives a group, slave is the scheduler.
interface wave_bit_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weight_in;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_in;

  modport master (output in_valid, output weight_in, output act_in, input in_ready);
  modport slave  (input in_valid, input weight_in, input act_in, output in_ready);
endinterface

// File: rtl/wave_bit_scheduler_col_priority_enc.sv
// rtl/wave_bit_scheduler_col_priority_enc.sv - highest-set-bit encoder for the column mask
// Ports: mask (in, pending columns), idx (out, highest set bit),
//        clear (out, one-hot of idx), last (out, exactly one bit set).
module col_priority_enc
  import wave_sched_pkg::*;
#(
  parameter int W = MAG_WIDTH
) (
  input  logic [W-1:0]             mask,
  output logic [COL_IDX_WIDTH-1:0] idx,
  output logic [W-1:0]             clear,
  output logic                     last
);

  always_comb begin
    idx   = '0;
    clear = '0;
    // Ascending scan: the highest set bit is the last one written.
    for (int i = 0; i < W; i++) begin
      if (mask[i]) begin
        idx   = COL_IDX_WIDTH'(i);
        clear = W'(1) << i;
      end
    end
    last = (mask != '0) && ((mask & (mask - W'(1))) == '0);
  end

endmodule

// File: rtl/wave_bit_scheduler.sv
// rtl/wave_bit_scheduler.sv - MSB-first bit-column scheduler feeding the 8-lane Wave MAC
// Ports: clk, reset (sync, active-high); grp (slave group handshake: in_valid,
//        in_ready, weight_in, act_in); act_out, sign_out, w_bit_out, column_idx,
//        mac_en, mac_load_accum (MAC controls); result_valid (group result final);
//        busy (group or issue pipe in flight).
module wave_bit_scheduler
  import wave_sched_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 8,
  parameter bit SKIP_ZERO_COL = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  wave_bit_scheduler_if.slave                   grp,
  output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_out,
  output logic [VEC_LENGTH-1:0]                 sign_out,
  output logic [VEC_LENGTH-1:0]                 w_bit_out,
  output logic [COL_IDX_WIDTH-1:0]              column_idx,
  output logic                                  mac_en,
  output logic                                  mac_load_accum,
  output logic                                  result_valid,
  output logic                                  busy
);

  localparam int MW = DATA_WIDTH - 1;

  sched_state_e state_q, state_d;

  logic [MW-1:0]                 col_mask_q;
  logic [VEC_LENGTH-1:0][MW-1:0] mag_q;
  logic [COL_IDX_WIDTH-1:0]      col_hold_q;
  logic                          first_q;
  // pipe_q[0]: column sitting in the MAC psum register; pipe_q[1]: column just accumulated.
  logic [1:0]                    pipe_q;
  logic                          pipe_first_q;
  logic [1:0]                    pipe_last_q;

  logic [COL_IDX_WIDTH-1:0] enc_idx;
  logic [MW-1:0]            enc_clear;
  logic                     enc_last;

  logic                     run;
  logic                     ready;
  logic                     accept;
  logic [MW-1:0]            or_mag;
  logic [MW-1:0]            new_mask;
  logic [VEC_LENGTH-1:0]    new_sign;

  col_priority_enc #(.W(MW)) u_enc (
    .mask  (col_mask_q),
    .idx   (enc_idx),
    .clear (enc_clear),
    .last  (enc_last)
  );

  assign run          = (state_q == RUN);
  assign ready        = !run || enc_last;
  assign accept       = grp.in_valid && ready;
  assign grp.in_ready = ready;

  // Column mask and signs for an incoming group; -0 is folded to +0 and an
  // all-zero group still gets one dummy column so the accumulator reloads.
  always_comb begin
    or_mag   = '0;
    new_sign = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      or_mag      = or_mag | grp.weight_in[j][MW-1:0];
      new_sign[j] = grp.weight_in[j][DATA_WIDTH-1] && (grp.weight_in[j][MW-1:0] != '0);
    end
    new_mask = SKIP_ZERO_COL ? or_mag : '1;
    if (new_mask == '0) begin
      new_mask = MW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    column_idx     = col_hold_q;
    w_bit_out      = '0;
    mac_en         = 1'b0;
    mac_load_accum = 1'b0;
    result_valid   = 1'b0;
    busy           = 1'b0;

    if (accept) begin
      state_d = RUN;
    end else if (run && enc_last) begin
      state_d = IDLE;
    end

    // While draining in IDLE the held index and zero bits add nothing to the sum.
    if (run) begin
      column_idx = enc_idx;
      for (int j = 0; j < VEC_LENGTH; j++) begin
        w_bit_out[j] = mag_q[j][enc_idx];
      end
    end

    mac_en         = run || (pipe_q != 2'b00);
    busy           = run || (pipe_q != 2'b00);
    mac_load_accum = pipe_q[0] && pipe_first_q;
    result_valid   = pipe_q[1] && pipe_last_q[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_out      <= '0;
      sign_out     <= '0;
      mag_q        <= '0;
      col_mask_q   <= '0;
      col_hold_q   <= '0;
      first_q      <= 1'b0;
      pipe_q       <= 2'b00;
      pipe_first_q <= 1'b0;
      pipe_last_q  <= 2'b00;
    end else begin
      pipe_q       <= {pipe_q[0], run};
      pipe_first_q <= run && first_q;
      pipe_last_q  <= {pipe_last_q[0], run && enc_last};

      if (run) begin
        col_hold_q <= enc_idx;
        first_q    <= 1'b0;
      end

      if (accept) begin
        act_out    <= grp.act_in;
        sign_out   <= new_sign;
        col_mask_q <= new_mask;
        first_q    <= 1'b1;
        for (int j = 0; j < VEC_LENGTH; j++) begin
          mag_q[j] <= grp.weight_in[j][MW-1:0];
        end
      end else if (run) begin
        col_mask_q <= col_mask_q & ~enc_clear;
      end
    end
  end

endmodule

// File: tb/tb_wave_bit_scheduler.sv
// tb/tb_wave_bit_scheduler.sv - self-checking bench for wave_bit_scheduler
// Ports: none (top-level bench); drives two DUTs, SKIP_ZERO_COL=1 and SKIP_ZERO_COL=0.
module tb_wave_bit_scheduler;

  typedef logic [7:0][7:0] vec_t;

  typedef struct {
    int         cyc;
    logic [2:0] idx;
    logic [7:0] wbit;
    logic [7:0] sign;
    vec_t       act;
    logic       rdy;
  } col_t;

  typedef struct {
    int         dut;
    vec_t       w;
    vec_t       a;
    int         rv_off;
    logic [7:0] sign;
  } tv_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   cur = 0;
  int   rv_seen = -1;

  col_t col_q[$];
  int   ld_q[$];
  int   rv_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wave_bit_scheduler_if #(.DATA_WIDTH(8), .VEC_LENGTH(8)) ifa ();
  wave_bit_scheduler_if #(.DATA_WIDTH(8), .VEC_LENGTH(8)) ifb ();

  vec_t       act_a, act_b;
  logic [7:0] sign_a, sign_b, wbit_a, wbit_b;
  logic [2:0] col_a, col_b;
  logic       en_a, en_b, ld_a, ld_b, rv_a, rv_b, busy_a, busy_b;

  wave_bit_scheduler #(.DATA_WIDTH(8), .VEC_LENGTH(8), .SKIP_ZERO_COL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .grp(ifa),
    .act_out(act_a), .sign_out(sign_a), .w_bit_out(wbit_a), .column_idx(col_a),
    .mac_en(en_a), .mac_load_accum(ld_a), .result_valid(rv_a), .busy(busy_a)
  );

  wave_bit_scheduler #(.DATA_WIDTH(8), .VEC_LENGTH(8), .SKIP_ZERO_COL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .grp(ifb),
    .act_out(act_b), .sign_out(sign_b), .w_bit_out(wbit_b), .column_idx(col_b),
    .mac_en(en_b), .mac_load_accum(ld_b), .result_valid(rv_b), .busy(busy_b)
  );

  vec_t       o_act;
  logic [7:0] o_sign, o_wbit;
  logic [2:0] o_col;
  logic       o_en, o_ld, o_rv, o_busy, o_rdy;

  assign o_act  = (cur == 0) ? act_a  : act_b;
  assign o_sign = (cur == 0) ? sign_a : sign_b;
  assign o_wbit = (cur == 0) ? wbit_a : wbit_b;
  assign o_col  = (cur == 0) ? col_a  : col_b;
  assign o_en   = (cur == 0) ? en_a   : en_b;
  assign o_ld   = (cur == 0) ? ld_a   : ld_b;
  assign o_rv   = (cur == 0) ? rv_a   : rv_b;
  assign o_busy = (cur == 0) ? busy_a : busy_b;
  assign o_rdy  = (cur == 0) ? ifa.in_ready : ifb.in_ready;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference schedule: columns MSB-first over the OR of lane magnitudes.
  task automatic push_group(input vec_t w, input vec_t a, input bit skip, input int acc);
    logic [6:0] m;
    int         ncols;
    int         k;
    col_t       e;
    m = '0;
    for (int j = 0; j < 8; j++) m = m | w[j][6:0];
    if (!skip) m = 7'h7F;
    if (m == 7'h00) m = 7'h01;
    ncols = 0;
    for (int b = 0; b < 7; b++) if (m[b]) ncols++;
    k = 0;
    for (int b = 6; b >= 0; b--) begin
      if (m[b]) begin
        e.cyc = acc + 1 + k;
        e.idx = 3'(b);
        for (int j = 0; j < 8; j++) begin
          e.wbit[j] = w[j][b];
          e.sign[j] = w[j][7] & (w[j][6:0] != 7'h00);
        end
        e.act = a;
        e.rdy = (k == ncols - 1);
        col_q.push_back(e);
        k++;
      end
    end
    ld_q.push_back(acc + 2);
    rv_q.push_back(acc + ncols + 2);
  endtask

  task automatic send(input int d, input vec_t w, input vec_t a, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    @(negedge clk);
    #1;
    if (d == 0) begin
      ifa.in_valid = 1'b1; ifa.weight_in = w; ifa.act_in = a;
    end else begin
      ifb.in_valid = 1'b1; ifb.weight_in = w; ifb.act_in = a;
    end
    for (int t = 0; t < 50; t++) begin
      if ((d == 0) ? ifa.in_ready : ifb.in_ready) begin
        acc = cyc;
        ok  = 1'b1;
        push_group(w, a, (d == 0), acc);
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("accept_handshake", 64'(ok), 64'd1);
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    #1;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  function automatic vec_t alt(input logic [7:0] even, input logic [7:0] odd);
    vec_t v;
    for (int j = 0; j < 8; j++) v[j] = (j % 2 == 0) ? even : odd;
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int j = 0; j < 8; j++) v[j] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  always @(negedge clk) begin : monitor
    col_t e;
    logic exp_ld;
    logic exp_rv;
    if (!reset) begin
      if (col_q.size() > 0 && col_q[0].cyc == cyc) begin
        e = col_q.pop_front();
        chk("column_idx", 64'(o_col), 64'(e.idx));
        chk("w_bit_out", 64'(o_wbit), 64'(e.wbit));
        chk("sign_out", 64'(o_sign), 64'(e.sign));
        chk("act_out", o_act, e.act);
        chk("mac_en_col", 64'(o_en), 64'd1);
        chk("in_ready_col", 64'(o_rdy), 64'(e.rdy));
      end else begin
        chk("w_bit_idle", 64'(o_wbit), 64'd0);
      end
      exp_ld = (ld_q.size() > 0 && ld_q[0] == cyc);
      if (exp_ld) void'(ld_q.pop_front());
      chk("mac_load_accum", 64'(o_ld), 64'(exp_ld));
      exp_rv = (rv_q.size() > 0 && rv_q[0] == cyc);
      if (exp_rv) void'(rv_q.pop_front());
      chk("result_valid", 64'(o_rv), 64'(exp_rv));
      if (o_rv) rv_seen = cyc;
    end
  end

  tv_t tab[9];
  int  acc, acc2;

  initial begin
    ifa.in_valid = 1'b0; ifa.weight_in = '0; ifa.act_in = '0;
    ifb.in_valid = 1'b0; ifb.weight_in = '0; ifb.act_in = '0;

    tab[0] = '{0, alt(8'h01, 8'h01), rnd_vec(), 3, 8'h00};
    tab[1] = '{0, alt(8'h7F, 8'h7F), rnd_vec(), 9, 8'h00};
    tab[2] = '{0, alt(8'h84, 8'h01), rnd_vec(), 4, 8'h55};
    tab[3] = '{0, alt(8'h00, 8'h00), rnd_vec(), 3, 8'h00};
    tab[4] = '{0, alt(8'h80, 8'h80), rnd_vec(), 3, 8'h00};
    tab[5] = '{0, alt(8'h00, 8'h00), rnd_vec(), 4, 8'h05};
    tab[5].w[0] = 8'hC0; tab[5].w[1] = 8'h08; tab[5].w[2] = 8'h88; tab[5].w[3] = 8'h80;
    tab[6] = '{1, alt(8'h84, 8'h01), rnd_vec(), 9, 8'h55};
    tab[7] = '{1, alt(8'h00, 8'h00), rnd_vec(), 9, 8'h00};
    tab[8] = '{0, alt(8'hFF, 8'hFF), rnd_vec(), 9, 8'hFF};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(ifa.in_ready), 64'd1);
    chk("rst_act_out", act_a, 64'd0);
    chk("rst_sign_out", 64'(sign_a), 64'd0);
    chk("rst_w_bit", 64'(wbit_a), 64'd0);
    chk("rst_column_idx", 64'(col_a), 64'd0);
    chk("rst_mac_en", 64'(en_a), 64'd0);
    chk("rst_load_accum", 64'(ld_a), 64'd0);
    chk("rst_result_valid", 64'(rv_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    #1 reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      cur = tab[i].dut;
      rv_seen = -1;
      send(cur, tab[i].w, tab[i].a, acc);
      drop();
      chk("tab_sign_out", 64'(o_sign), 64'(tab[i].sign));
      wait_cyc(acc + tab[i].rv_off + 1);
      chk("tab_result_cycle", 64'(rv_seen - acc), 64'(tab[i].rv_off));
      chk("tab_mac_en_drained", 64'(o_en), 64'd0);
      chk("tab_busy_drained", 64'(o_busy), 64'd0);
      chk("tab_in_ready_idle", 64'(o_rdy), 64'd1);
    end

    // Two back-to-back 0x03 groups with in_valid held high.
    cur = 0;
    rv_seen = -1;
    send(0, alt(8'h03, 8'h03), rnd_vec(), acc);
    send(0, alt(8'h03, 8'h03), rnd_vec(), acc2);
    drop();
    chk("b2b_accept_gap", 64'(acc2 - acc), 64'd2);
    wait_cyc(acc + 7);
    chk("b2b_last_result", 64'(rv_seen - acc), 64'd6);
    chk("b2b_mac_en_drained", 64'(o_en), 64'd0);

    // 0x7F group cut off by reset in cycle 4.
    send(0, alt(8'h7F, 8'h7F), rnd_vec(), acc);
    drop();
    wait_cyc(acc + 4);
    #1;
    col_q.delete();
    ld_q.delete();
    rv_q.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(ifa.in_ready), 64'd1);
    chk("mid_rst_act_out", act_a, 64'd0);
    chk("mid_rst_sign_out", 64'(sign_a), 64'd0);
    chk("mid_rst_w_bit", 64'(wbit_a), 64'd0);
    chk("mid_rst_column_idx", 64'(col_a), 64'd0);
    chk("mid_rst_mac_en", 64'(en_a), 64'd0);
    chk("mid_rst_load_accum", 64'(ld_a), 64'd0);
    chk("mid_rst_result_valid", 64'(rv_a), 64'd0);
    chk("mid_rst_busy", 64'(busy_a), 64'd0);
    #1 reset = 1'b0;
    rv_seen = -1;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_result", 64'(rv_seen), 64'(-1));

    chk("sb_columns_left", 64'(col_q.size()), 64'd0);
    chk("sb_loads_left", 64'(ld_q.size()), 64'd0);
    chk("sb_results_left", 64'(rv_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_bit_scheduler.md
Name: wave_bit_scheduler

Overview:
- Upstream control/feed stage for the bit-serial 8-lane Wave MAC unit.
- Accepts one group per valid/ready handshake. A group is VEC_LENGTH sign-magnitude weights plus VEC_LENGTH activations.
- Walks the weight magnitude bit-columns MSB-first and skips all-zero columns. Each cycle it drives the MAC's per-lane sign/w_bit, column_idx, en and load_accum.
- Pulses result_valid when the MAC accumulator holds the finished group result.

Parameters:
- DATA_WIDTH, 8, activation and weight width; weight bit DATA_WIDTH-1 = sign, bits DATA_WIDTH-2..0 = magnitude.
- VEC_LENGTH, 8, lanes per group.
- SKIP_ZERO_COL, 1, 1 = skip columns whose magnitude bit is 0 in every lane; 0 = issue all DATA_WIDTH-1 columns.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  group available
- in_ready  out  1  scheduler can accept a group this cycle
- weight_in  in  VEC_LENGTH x DATA_WIDTH  sign-magnitude weights
- act_in  in  VEC_LENGTH x DATA_WIDTH signed  activations
- act_out  out  VEC_LENGTH x DATA_WIDTH signed  latched activations to MAC act_in
- sign_out  out  VEC_LENGTH x 1  per-lane weight sign to MAC sign
- w_bit_out  out  VEC_LENGTH x 1  current-column magnitude bit per lane
- column_idx  out  3  current column number (shift amount)
- mac_en  out  1  MAC enable
- mac_load_accum  out  1  MAC load_accum
- result_valid  out  1  one-cycle pulse: MAC result is final for the group
- busy  out  1  group or pipeline in flight

Behaviour:
- Reset: state IDLE. in_ready=1. act_out, sign_out, w_bit_out, column_idx, mac_en, mac_load_accum, result_valid and busy are all 0. Pending mask and the 2-bit issue pipe are cleared.
- Reset mid-group: the group is discarded and result_valid is never pulsed for it.
- Accept: a handshake (in_valid & in_ready) at an edge latches the following, and the state becomes RUN:
  - act_out = act_in.
  - sign_out[j] = weight_in[j][DATA_WIDTH-1] & (magnitude != 0), so -0 is treated as +0.
  - col_mask = OR of the lane magnitudes (all-ones when SKIP_ZERO_COL=0).
- Empty mask (all weights zero): col_mask is forced to bit 0 only. Exactly one dummy column (idx 0, w_bit all 0) is issued so the accumulator is still reloaded.
- RUN, each cycle:
  - column_idx = highest set bit of col_mask.
  - w_bit_out[j] = magnitude[j][column_idx].
  - mac_en = 1.
  - That bit is cleared from col_mask at the edge.
  - When the cleared bit was the last one, the state goes to IDLE, unless a new group is accepted at the same edge, in which case it stays RUN.
- Issue pipe:
  - A column issued in cycle c is in the MAC psum register in c+1 and in the accumulator from c+2.
  - mac_load_accum = 1 in cycle f+1, where f is the group's first column cycle.
  - result_valid = 1 in cycle L+2, where L is the group's last column cycle.
- Drain:
  - mac_en stays 1 in any cycle where the issue pipe holds an un-accumulated column.
  - While draining in IDLE, w_bit_out = 0 and column_idx is held, so the contributions are zero.
  - mac_en = 0 only when idle and the pipe is empty.
- in_ready = (state==IDLE) | (state==RUN & exactly one col_mask bit set). This gives back-to-back groups with no bubble.
- Overlap: load_accum for group N+1 may coincide with the drain of group N. This is legal because load_accum replaces accum_out only for the new group's first column.
- act_out and sign_out are stable for the whole group. They change only at the accept edge.
- busy = (state==RUN) | pipe nonzero.
- Columns per group = popcount(col_mask), minimum 1, maximum DATA_WIDTH-1.

Decomposition:
- Package wave_sched_pkg: state enum {IDLE, RUN}, MAG_WIDTH = DATA_WIDTH-1, COL_IDX_WIDTH = 3.
- Sub-module col_priority_enc: MAG_WIDTH-bit mask -> highest set index, a one-hot clear vector, and a last flag.

Test Plan:
- All weights 0x01, accept in cycle 0 -> one column, idx 0, w_bit=0xFF in cycle 1; load_accum in cycle 2; result_valid in cycle 3; mac_en=0 from cycle 4.
- All weights 0x7F -> columns 6,5,...,0 in cycles 1-7; load_accum in cycle 2; result_valid in cycle 9; in_ready=1 in cycle 7.
- Lanes 0x84/0x01 alternating -> columns 2 then 0 (column 1 skipped); sign_out=0x55; w_bit 0x55 then 0xAA; result_valid in cycle 4. Same stimulus with SKIP_ZERO_COL=0 -> columns 6..0 issued, 7 cycles.
- All weights 0x00 and 0x80 -> one dummy column idx 0, w_bit=0, sign_out=0; result_valid in cycle 3.
- Two groups back-to-back (0x03 vectors, in_valid held) -> second group accepted at the last-column edge of the first, no idle cycle; load_accum in cycles 2 and 4; result_valid in cycles 4 and 6.
- 0x7F group, reset asserted in cycle 4 -> in cycle 5 all outputs 0 and in_ready=1; no result_valid for the group.
